ls7404_pipe: RTL and testbench
==============================

Name: ls7404_pipe

Overview:
- Parametrised, pipelined successor to the hex inverter model.
- Carries WIDTH-bit words through STAGES register stages with a valid/ready handshake.
- Each beat is transformed by a per-beat mode: pass, full invert, mask-invert, or constant-drive.
- Sits between CPU datapath elements that need a registered, back-pressurable inverter.
- Also counts transformed beats for debug.

Parameters:
- WIDTH, 6, data width in bits (1..32).
- STAGES, 2, pipeline register stages, i.e. latency in cycles (1..8).
- MASK_RST, {WIDTH{1'b1}}, reset value of the invert-mask register.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low (sampled on the clk rising edge)
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  input word
- mode  in  2  per-beat transform: 00 pass, 01 invert, 10 a XOR mask, 11 drive mask
- mask_we  in  1  write enable for the mask register
- mask_in  in  WIDTH  new mask value
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts the output beat
- y  out  WIDTH  output word
- beat_cnt  out  CNT_W  count of beats delivered with mode != 00, saturating
- busy  out  1  at least one stage holds a valid beat

Behaviour:
- One clock domain. Reset is synchronous, active-low, and overrides everything else in that cycle.
- Reset values:
  - all stage valid bits 0, so out_valid=0 and busy=0
  - y=0 and all stage data registers 0
  - mask=MASK_RST
  - beat_cnt=0
  - in_ready=1 in the first cycle after reset release
- Transform is applied combinationally at input, before stage 0:
  - 00: y=a
  - 01: y=~a
  - 10: y=a^mask
  - 11: y=mask
  - The mode of each beat travels with it as a 1-bit "transformed" flag (mode!=00).
- Acceptance: a beat is accepted when in_valid && in_ready.
- Output delivery: a beat is delivered when out_valid && out_ready.
- Stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready=1.
- in_ready = (stage 0 empty) OR (stage 0 advances). This is combinational from out_ready through the chain; no skid buffer.
- Latency: with out_ready held at 1, a beat accepted at cycle N appears on y with out_valid=1 in cycle N+STAGES.
- Throughput: one beat per cycle with no bubbles while out_ready=1.
- Back-pressure:
  - while out_ready=0, y and out_valid are held stable;
  - the pipeline compresses bubbles until every stage is full, then in_ready=0;
  - capacity is exactly STAGES beats.
- No data loss or duplication under any in_valid/out_ready pattern.
- Ordering is strictly FIFO.
- Mask write:
  - mask updates at the clock edge when mask_we=1;
  - a beat accepted in the same cycle uses the OLD mask;
  - beats already in flight are unaffected, because the transform happens at input.
- beat_cnt increments by 1 on each delivered beat whose flag is set and saturates at all-ones (no wrap). Pass-mode beats are not counted.
- busy = OR of all stage valid bits.
- Reset mid-operation: in-flight beats are discarded, and y/out_valid/busy go to their reset values in the next cycle.
- A beat presented with in_valid=1 during reset is not accepted.
- STAGES=1 is a single register slice with the same rules.

Decomposition:
- Shared package `ls74_pkg`:
  - mode encodings MODE_PASS=2'b00, MODE_INV=2'b01, MODE_XMASK=2'b10, MODE_MASK=2'b11
  - a transform function taking (word, mode, mask) and returning the word
- One natural sub-module, `ls74_pipe_stage`: a single valid/ready register slice carrying data plus flag, instantiated STAGES times via generate.
- Top-level contents: mask register, transform, counter, busy reduction.

Test Plan:
- Basic invert, WIDTH=6, STAGES=2, out_ready=1: a=6'b001010, mode=01, one beat → y=6'b110101 with out_valid=1 exactly 2 cycles after acceptance, then out_valid=0; beat_cnt=1.
- Streaming: a=6'b000101 with mode 01, then a=6'b000101 with mode 00, on back-to-back cycles → y=6'b111010 then 6'b000101 on consecutive cycles; beat_cnt=1.
- Mask path:
  - after reset, mode=10, a=6'b101010 → y=6'b010101 (MASK_RST all ones);
  - same cycle mask_we=1, mask_in=6'b000011; next beat mode=10, a=6'b101010 → y=6'b101001;
  - then mode=11 → y=6'b000011.
- Back-pressure: hold out_ready=0 and offer 4 beats 1,2,3,4 in pass mode → only 2 accepted, in_ready=0, y=1 held stable; release out_ready → outputs 1,2,3,4 in order with no loss.
- Reset mid-operation: with 2 beats in flight, rst_n=0 for one clk → next cycle out_valid=0, busy=0, y=0, mask=6'b111111, beat_cnt=0; a beat offered during reset is never delivered.
- Saturation: CNT_W=2, deliver 5 beats in mode 01 → beat_cnt reads 3 after the 3rd through 5th deliveries.

Source files
------------

// File: rtl/ls74_pkg.sv
// rtl/ls74_pkg.sv - mode encodings and per-bit transform for the ls7404 pipeline
package ls74_pkg;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_INV   = 2'b01;
  localparam logic [1:0] MODE_XMASK = 2'b10;
  localparam logic [1:0] MODE_MASK  = 2'b11;

  // Bit-sliced so any WIDTH can apply it without truncating a wider word.
  function automatic logic ls74_transform(input logic word, input logic [1:0] mode,
                                          input logic mask);
    logic res;
    case (mode)
      MODE_PASS:  res = word;
      MODE_INV:   res = ~word;
      MODE_XMASK: res = word ^ mask;
      default:    res = mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ls74_pipe_stage.sv
// rtl/ls74_pipe_stage.sv - one valid/ready register slice carrying data plus transformed flag
module ls74_pipe_stage #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             flag_q, flag_d;

  // A slice advances when empty or when its content leaves downstream.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        flag_d = in_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_flag  = flag_q;

endmodule

// File: rtl/ls7404_pipe.sv
// rtl/ls7404_pipe.sv - pipelined, back-pressurable inverter with mask register and beat counter
module ls7404_pipe
  import ls74_pkg::*;
#(
  parameter int               WIDTH    = 6,
  parameter int               STAGES   = 2,
  parameter logic [WIDTH-1:0] MASK_RST = {WIDTH{1'b1}},
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Index 0 is the input side, index STAGES the output side of the chain.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  flg;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [WIDTH-1:0] xf;

  always_comb begin
    xf = '0;
    for (int i = 0; i < WIDTH; i++) begin
      xf[i] = ls74_transform(a[i], mode, mask_q[i]);
    end
  end

  assign vld[0]      = in_valid;
  assign dat[0]      = xf;
  assign flg[0]      = (mode != MODE_PASS);
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ls74_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .in_flag   (flg[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1]),
      .out_flag  (flg[k+1])
    );
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_in;
    end
  end

  // Only transformed beats count, and the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (vld[STAGES] && out_ready && flg[STAGES] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= MASK_RST;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld[STAGES];
  assign y         = dat[STAGES];
  assign beat_cnt  = cnt_q;
  assign busy      = |vld[STAGES:1];

endmodule

// File: tb/tb_ls7404_pipe.sv
// tb/tb_ls7404_pipe.sv - directed self-checking bench for ls7404_pipe (WIDTH=6, STAGES=2, CNT_W=2)
module tb_ls7404_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a;
  logic [1:0] mode;
  logic       mask_we;
  logic [5:0] mask_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] y;
  logic [1:0] beat_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  ls7404_pipe #(.WIDTH(6), .STAGES(2), .MASK_RST(6'b111111), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .mode      (mode),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .beat_cnt  (beat_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    a        = '0;
    mode     = 2'b00;
    mask_we  = 1'b0;
    mask_in  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (y !== 6'b000000) begin n_fail++; $display("FAIL reset_y got %b want 000000", y); end
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_invert();
    do_reset();
    in_valid = 1'b1; a = 6'b001010; mode = 2'b01;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_accept got %b want 1", in_ready); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inv_early got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL inv_busy got %b want 1", busy); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inv_valid got %b want 1", out_valid); end
    n_checks++; if (y !== 6'b110101) begin n_fail++; $display("FAIL inv_y got %b want 110101", y); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inv_after got %b want 0", out_valid); end
    n_checks++; if (beat_cnt !== 2'd1) begin n_fail++; $display("FAIL inv_cnt got %0d want 1", beat_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inv_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_streaming();
    do_reset();
    in_valid = 1'b1; a = 6'b000101; mode = 2'b01;
    next_cycle();
    in_valid = 1'b1; a = 6'b000101; mode = 2'b00;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b111010) begin n_fail++; $display("FAIL stream_b0 got v=%b y=%b want v=1 y=111010", out_valid, y); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b000101) begin n_fail++; $display("FAIL stream_b1 got v=%b y=%b want v=1 y=000101", out_valid, y); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b want 0", out_valid); end
    n_checks++; if (beat_cnt !== 2'd1) begin n_fail++; $display("FAIL stream_cnt got %0d want 1", beat_cnt); end
  endtask

  task automatic test_mask();
    do_reset();
    in_valid = 1'b1; a = 6'b101010; mode = 2'b10; mask_we = 1'b1; mask_in = 6'b000011;
    next_cycle();
    mask_we = 1'b0; mask_in = '0;
    in_valid = 1'b1; a = 6'b101010; mode = 2'b10;
    next_cycle();
    in_valid = 1'b1; a = 6'b111111; mode = 2'b11;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b010101) begin n_fail++; $display("FAIL mask_old got v=%b y=%b want v=1 y=010101", out_valid, y); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b101001) begin n_fail++; $display("FAIL mask_new got v=%b y=%b want v=1 y=101001", out_valid, y); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b000011) begin n_fail++; $display("FAIL mask_drive got v=%b y=%b want v=1 y=000011", out_valid, y); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (beat_cnt !== 2'd3) begin n_fail++; $display("FAIL mask_cnt got %0d want 3", beat_cnt); end
  endtask

  task automatic test_backpressure();
    logic       exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] got [$];
    int         idx = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4); a = 6'(idx + 1); mode = 2'b00;
      @(negedge clk);
      n_checks++; if (in_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL bp_in_ready c%0d got %b want %b", c, in_ready, exp_rdy[c]); end
      if (c >= 2) begin
        n_checks++; if (out_valid !== 1'b1 || y !== 6'd1) begin n_fail++; $display("FAIL bp_hold c%0d got v=%b y=%0d want v=1 y=1", c, out_valid, y); end
      end
      if (in_valid && in_ready) idx++;
      next_cycle();
    end
    n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      in_valid = (idx < 4); a = 6'(idx + 1); mode = 2'b00;
      @(negedge clk);
      if (out_valid) got.push_back(y);
      if (in_valid && in_ready) idx++;
      next_cycle();
    end
    idle_inputs();
    n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++; if (got[i] !== 6'(i + 1)) begin n_fail++; $display("FAIL bp_order i%0d got %0d want %0d", i, got[i], i + 1); end
    end
    @(negedge clk);
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL bp_cnt got %0d want 0", beat_cnt); end
  endtask

  // Runs straight after test_mask so beat_cnt is non-zero going into reset.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 6'd1; mode = 2'b01;
    next_cycle();
    in_valid = 1'b1; a = 6'd2; mode = 2'b01;
    next_cycle();
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    next_cycle();
    rst_n = 1'b0; in_valid = 1'b1; a = 6'd7; mode = 2'b00; mask_we = 1'b1; mask_in = 6'b000000;
    out_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_checks++; if (y !== 6'b000000) begin n_fail++; $display("FAIL rmid_y got %b want 000000", y); end
    n_checks++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d want 0", beat_cnt); end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost c%0d got %b want 0", c, out_valid); end
    end
    next_cycle();
    in_valid = 1'b1; a = 6'b000000; mode = 2'b11;
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || y !== 6'b111111) begin n_fail++; $display("FAIL rmid_mask got v=%b y=%b want v=1 y=111111", out_valid, y); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 5); a = 6'(c); mode = 2'b01;
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        n_checks++; if (out_valid !== 1'b1 || y !== ~6'(c - 2)) begin n_fail++; $display("FAIL sat_y c%0d got v=%b y=%b want v=1 y=%b", c, out_valid, y, ~6'(c - 2)); end
      end
      if (c >= 3 && c <= 7) begin
        n_checks++; if (beat_cnt !== exp_cnt[c-3]) begin n_fail++; $display("FAIL sat_cnt c%0d got %0d want %0d", c, beat_cnt, exp_cnt[c-3]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_basic_invert();
    test_streaming();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
